// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser (LSB first).
// Status word exposes count/ovf/busy/full/empty for CPU polling.
module uart_tx_io #(
  parameter int unsigned CLKS_PER_BIT = 200,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_we,
  input  logic [7:0]  tx_data,
  input  logic        clr_ovf,
  output logic [31:0] status,
  output logic        busy,
  output logic        tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                ovf_q;
  logic                full, empty, push, pop, baud_end;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  // A pop in the same cycle frees a slot, so a write into a full FIFO still succeeds.
  assign push     = tx_we && (!full || pop);
  assign baud_end = (baud_q == BAUD_LAST);

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (tx_we && full && !pop) ovf_q <= 1'b1;
      else if (clr_ovf)          ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // Serialiser state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx     = tx_q;
  assign busy   = busy_q;
  assign status = {16'b0, 8'(count_q), 4'b0, ovf_q, busy_q, full, empty};

endmodule
